// File: rtl/floor_scheduler.sv
// floor_scheduler: latches car/hall calls and picks the next target floor with a SCAN (direction-retaining) policy
module floor_scheduler #(
  parameter int NFLOORS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] in,
  input  logic [NFLOORS-1:0] out,
  input  logic [3:0]         floor,
  input  logic               arrived,
  input  logic               sos_en,
  output logic [NFLOORS-1:0] pending,
  output logic [3:0]         target,
  output logic               target_vld,
  output logic               dir_up,
  output logic               dir_dn
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, SOS} state_t;
  state_t state, state_nx;
  logic [3:0] target_nx, lo_a, hi_b, dist_a, dist_b;
  logic vld_nx, fvalid, here, has_a, has_b;
  logic [NFLOORS-1:0] above, below, at, clr;
  always_comb begin
    fvalid = floor != 4'd0 && int'(floor) <= NFLOORS;
    above = '0;
    below = '0;
    at = '0;
    lo_a = 4'd0;
    hi_b = 4'd0;
    for (int i = 0; i < NFLOORS; i++) begin
      at[i] = fvalid && floor == 4'(i + 1);
      above[i] = pending[i] && int'(floor) < i + 1;
      below[i] = pending[i] && int'(floor) > i + 1;
    end
    for (int i = NFLOORS - 1; i >= 0; i--) lo_a = above[i] ? 4'(i + 1) : lo_a;
    for (int i = 0; i < NFLOORS; i++) hi_b = below[i] ? 4'(i + 1) : hi_b;
    has_a = |above;
    has_b = |below;
    here = |(pending & at);
    clr = arrived ? at : '0;
    dist_a = lo_a - floor;
    dist_b = floor - hi_b;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      state <= IDLE;
      target <= 4'd0;
      target_vld <= 1'b0;
    end else begin
      pending <= sos_en ? '0 : (pending | in | out) & ~clr;
      state <= state_nx;
      target <= target_nx;
      target_vld <= vld_nx;
    end
  end
  // an invalid floor freezes selection; SOS overrides everything
  always_comb begin
    state_nx = state;
    target_nx = target;
    if (sos_en) begin
      state_nx = SOS;
      target_nx = 4'd0;
    end else if (state == SOS) begin
      state_nx = IDLE;
      target_nx = 4'd0;
    end else if (fvalid) begin
      case (state)
        IDLE: begin
          state_nx = here ? IDLE : (has_b && (!has_a || dist_b <= dist_a)) ? DOWN : has_a ? UP : IDLE;
          target_nx = here ? floor : (has_b && (!has_a || dist_b <= dist_a)) ? hi_b : has_a ? lo_a : 4'd0;
        end
        UP: begin
          state_nx = (has_a || here) ? UP : has_b ? DOWN : IDLE;
          target_nx = has_a ? lo_a : here ? floor : has_b ? hi_b : 4'd0;
        end
        DOWN: begin
          state_nx = (has_b || here) ? DOWN : has_a ? UP : IDLE;
          target_nx = has_b ? hi_b : here ? floor : has_a ? lo_a : 4'd0;
        end
        default: begin
          state_nx = IDLE;
          target_nx = 4'd0;
        end
      endcase
    end
    vld_nx = target_nx != 4'd0;
  end
  always_comb begin
    dir_up = state == UP;
    dir_dn = state == DOWN;
  end
endmodule

// File: tb/tb_floor_scheduler.sv
// tb_floor_scheduler: directed scenarios plus random traffic, checked against a rule-level SCAN model
module tb_floor_scheduler;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] in_b = '0, out_b = '0, pending;
  logic [3:0] floor = 4'd1, target;
  logic arrived = 1'b0, sos_en = 1'b0, target_vld, dir_up, dir_dn;
  int checks = 0, passed = 0;
  // model: m_st 0 idle, 1 sweeping up, 2 sweeping down, 3 emergency
  logic [N-1:0] m_pend = '0;
  int m_st = 0, m_tgt = 0;

  floor_scheduler #(.NFLOORS(N)) dut (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b), .floor(floor), .arrived(arrived),
    .sos_en(sos_en), .pending(pending), .target(target), .target_vld(target_vld),
    .dir_up(dir_up), .dir_dn(dir_dn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_model();
    check("pending", 32'(pending), 32'(m_pend));
    check("target", 32'(target), 32'(m_tgt));
    check("target_vld", 32'(target_vld), 32'(m_tgt != 0));
    check("dir_up", 32'(dir_up), 32'(m_st == 1));
    check("dir_dn", 32'(dir_dn), 32'(m_st == 2));
  endtask

  task automatic cycle(input logic [N-1:0] ci, input logic [N-1:0] co, input int fl,
                       input logic ar, input logic so);
    logic [N-1:0] np, clr;
    int na = 0, nb = 0, ns, nt;
    bit here = 0, v;
    in_b = ci; out_b = co; floor = 4'(fl); arrived = ar; sos_en = so;
    v = fl >= 1 && fl <= N;
    clr = '0;
    if (ar && v) clr[fl-1] = 1'b1;
    np = so ? '0 : (m_pend | ci | co) & ~clr;
    if (v) begin
      for (int f = N; f > fl; f--) if (m_pend[f-1]) na = f;
      for (int f = 1; f < fl; f++) if (m_pend[f-1]) nb = f;
      here = m_pend[fl-1];
    end
    ns = m_st; nt = m_tgt;
    if (so) begin ns = 3; nt = 0; end
    else if (m_st == 3) begin ns = 0; nt = 0; end
    else if (v) begin
      if (m_st == 0) begin
        if (here) nt = fl;
        else if (nb != 0 && (na == 0 || fl - nb <= na - fl)) begin ns = 2; nt = nb; end
        else if (na != 0) begin ns = 1; nt = na; end
        else nt = 0;
      end else if (m_st == 1) begin
        if (na != 0) nt = na;
        else if (here) nt = fl;
        else if (nb != 0) begin ns = 2; nt = nb; end
        else begin ns = 0; nt = 0; end
      end else begin
        if (nb != 0) nt = nb;
        else if (here) nt = fl;
        else if (na != 0) begin ns = 1; nt = na; end
        else begin ns = 0; nt = 0; end
      end
    end
    @(posedge clk);
    m_pend = np; m_st = ns; m_tgt = nt;
    #1 check_model();
  endtask

  task automatic flush(input int fl);
    cycle('0, '0, fl, 1'b0, 1'b1);
    cycle('0, '0, fl, 1'b0, 1'b0);
  endtask

  initial begin
    // T1: reset held with buttons pressed, then first capture one edge after release
    in_b = 4'hf; out_b = 4'h3; floor = 4'd2;
    repeat (3) @(posedge clk);
    #1 check("rst_pending", 32'(pending), 0);
    check("rst_target", 32'(target), 0);
    check("rst_vld", 32'(target_vld), 0);
    check("rst_dir", 32'({dir_up, dir_dn}), 0);
    #2 rst = 1'b1;
    cycle(4'hf, 4'h0, 2, 1'b0, 1'b0);
    check("t1_capture", 32'(pending), 32'hf);
    flush(2);
    check("t1_flushed", 32'(pending), 0);
    // T2: nearest pending floor from idle, then reversal after arriving at 1
    cycle(4'b1001, '0, 2, 1'b0, 1'b0);
    cycle('0, '0, 2, 1'b0, 1'b0);
    check("t2_target1", 32'(target), 1);
    check("t2_dn", 32'(dir_dn), 1);
    cycle('0, '0, 1, 1'b1, 1'b0);
    cycle('0, '0, 1, 1'b0, 1'b0);
    check("t2_pending", 32'(pending), 32'b1000);
    check("t2_target4", 32'(target), 4);
    check("t2_up", 32'(dir_up), 1);
    flush(2);
    // equal distance: lower floor wins
    cycle(4'b0101, '0, 2, 1'b0, 1'b0);
    cycle('0, '0, 2, 1'b0, 1'b0);
    check("tie_target", 32'(target), 1);
    check("tie_dn", 32'(dir_dn), 1);
    flush(1);
    // T3: a request ahead of the car preempts the current target
    cycle('0, 4'b1000, 1, 1'b0, 1'b0);
    cycle('0, '0, 1, 1'b0, 1'b0);
    check("t3_target4", 32'(target), 4);
    cycle(4'b0100, '0, 2, 1'b0, 1'b0);
    cycle('0, '0, 2, 1'b0, 1'b0);
    check("t3_preempt", 32'(target), 3);
    cycle('0, '0, 3, 1'b1, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    check("t3_resume", 32'(target), 4);
    flush(2);
    // T4: reversal at the end of an upward sweep, then back to idle
    cycle(4'b0100, '0, 2, 1'b0, 1'b0);
    cycle(4'b0001, '0, 2, 1'b0, 1'b0);
    cycle('0, '0, 3, 1'b1, 1'b0);
    cycle('0, '0, 3, 1'b0, 1'b0);
    check("t4_target1", 32'(target), 1);
    check("t4_dn", 32'(dir_dn), 1);
    cycle('0, '0, 1, 1'b1, 1'b0);
    cycle('0, '0, 1, 1'b0, 1'b0);
    check("t4_idle_vld", 32'(target_vld), 0);
    check("t4_idle_dir", 32'({dir_up, dir_dn}), 0);
    // T5: request at the current floor while idle
    cycle(4'b0010, '0, 2, 1'b0, 1'b0);
    cycle('0, '0, 2, 1'b0, 1'b0);
    check("t5_target", 32'(target), 2);
    check("t5_vld", 32'(target_vld), 1);
    check("t5_idle", 32'({dir_up, dir_dn}), 0);
    cycle(4'b0010, '0, 2, 1'b1, 1'b0);
    check("t5_clear_wins", 32'(pending), 0);
    cycle('0, '0, 2, 1'b0, 1'b0);
    check("t5_vld_off", 32'(target_vld), 0);
    // T6: emergency flushes and ignores buttons
    cycle(4'b1110, '0, 1, 1'b0, 1'b0);
    check("t6_pending", 32'(pending), 32'b1110);
    cycle(4'b1111, 4'b1111, 1, 1'b0, 1'b1);
    check("t6_sos_pending", 32'(pending), 0);
    check("t6_sos_vld", 32'(target_vld), 0);
    cycle(4'b1111, '0, 1, 1'b0, 1'b1);
    cycle('0, '0, 1, 1'b0, 1'b0);
    cycle(4'b0100, '0, 1, 1'b0, 1'b0);
    cycle('0, '0, 1, 1'b0, 1'b0);
    check("t6_target", 32'(target), 3);
    check("t6_up", 32'(dir_up), 1);
    // invalid floor holds selection but keeps capturing
    cycle(4'b0001, '0, 0, 1'b1, 1'b0);
    check("inv_hold", 32'(target), 3);
    check("inv_capture", 32'(pending), 32'b0101);
    // random traffic including invalid floors and rare emergencies
    for (int k = 0; k < 400; k++)
      cycle(4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0));
    // asynchronous reset mid-sweep
    cycle('0, 4'b1000, 1, 1'b0, 1'b0);
    cycle('0, '0, 1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check("arst_pending", 32'(pending), 0);
    check("arst_target", 32'(target), 0);
    check("arst_vld", 32'(target_vld), 0);
    check("arst_dir", 32'({dir_up, dir_dn}), 0);
    m_pend = '0; m_st = 0; m_tgt = 0;
    #2 rst = 1'b1;
    cycle('0, '0, 1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
